// File: rtl/conv1_pkg.sv
// Shared constants, FSM state encoding and image address helper for the conv1 stream engine.
package conv1_pkg;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 40;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int IN_DIM  = 227;
  localparam int CH      = 3;
  localparam int K       = 11;
  localparam int STRIDE  = 4;
  localparam int OUT_DIM = 55;

  localparam int IMG_AW  = 18;
  localparam int KER_AW  = 9;
  localparam int COORD_W = 6;
  localparam int POS_W   = 9;
  localparam int K_W     = $clog2(K);
  localparam int CH_W    = $clog2(CH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  function automatic logic [IMG_AW-1:0] img_addr_f(input int row, input int col, input int c,
                                                   input int in_dim);
    int a;
    a = ((row * in_dim) + col) * CH + c;
    return a[IMG_AW-1:0];
  endfunction
endpackage

// File: rtl/conv1_stream_engine_if.sv
// Memory read bus and result stream between the conv1 engine (master) and its environment (slave).
interface conv1_stream_engine_if;
  import conv1_pkg::*;
  logic                img_rd;
  logic [IMG_AW-1:0]   img_addr;
  logic [DATA_W-1:0]   img_rdata;
  logic [KER_AW-1:0]   ker_addr;
  logic [DATA_W-1:0]   ker_rdata;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [COORD_W-1:0]  out_row;
  logic [COORD_W-1:0]  out_col;
  logic                out_last;

  modport master (
    output img_rd, img_addr, ker_addr, out_valid, out_data, out_row, out_col, out_last,
    input  img_rdata, ker_rdata, out_ready
  );
  modport slave (
    input  img_rd, img_addr, ker_addr, out_valid, out_data, out_row, out_col, out_last,
    output img_rdata, ker_rdata, out_ready
  );
endinterface

// File: rtl/conv1_addr_gen.sv
// Pixel (i,j) and tap (m,n,c) counters with image bounds check and SRAM/ROM address generation.
module conv1_addr_gen
  import conv1_pkg::*;
#(
  parameter int IN_DIM_P  = IN_DIM,
  parameter int OUT_DIM_P = OUT_DIM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tap_en,
  input  logic                pix_en,
  output logic [IMG_AW-1:0]   img_addr,
  output logic [KER_AW-1:0]   ker_addr,
  output logic                in_bounds,
  output logic                last_tap,
  output logic                last_pix,
  output logic [COORD_W-1:0]  pix_row,
  output logic [COORD_W-1:0]  pix_col
);
  logic [COORD_W-1:0] i_q, i_d, j_q, j_d;
  logic [K_W-1:0]     m_q, m_d, n_q, n_d;
  logic [CH_W-1:0]    c_q, c_d;
  logic [POS_W-1:0]   row, col;

  always_comb begin
    row       = POS_W'(i_q) * POS_W'(STRIDE) + POS_W'(m_q);
    col       = POS_W'(j_q) * POS_W'(STRIDE) + POS_W'(n_q);
    in_bounds = (row < POS_W'(IN_DIM_P)) && (col < POS_W'(IN_DIM_P));
    img_addr  = img_addr_f(int'(row), int'(col), int'(c_q), IN_DIM_P);
    ker_addr  = KER_AW'((int'(m_q) * K + int'(n_q)) * CH + int'(c_q));
    last_tap  = (m_q == K_W'(K - 1)) && (n_q == K_W'(K - 1)) && (c_q == CH_W'(CH - 1));
    last_pix  = (i_q == COORD_W'(OUT_DIM_P - 1)) && (j_q == COORD_W'(OUT_DIM_P - 1));
    pix_row   = i_q;
    pix_col   = j_q;
  end

  // Tap counters wrap to zero after the last tap, so the next pixel starts clean.
  always_comb begin
    m_d = m_q;
    n_d = n_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    if (tap_en) begin
      if (c_q == CH_W'(CH - 1)) begin
        c_d = '0;
        if (n_q == K_W'(K - 1)) begin
          n_d = '0;
          m_d = (m_q == K_W'(K - 1)) ? '0 : m_q + 1'b1;
        end else begin
          n_d = n_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
    if (pix_en) begin
      if (j_q == COORD_W'(OUT_DIM_P - 1)) begin
        j_d = '0;
        i_d = (i_q == COORD_W'(OUT_DIM_P - 1)) ? '0 : i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      m_q <= '0;
      n_q <= '0;
      c_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      m_q <= m_d;
      n_q <= n_d;
      c_q <= c_d;
    end
  end
endmodule

// File: rtl/conv1_stream_engine.sv
// Sequential conv1: one MAC per cycle over each 11x11x3 window, results on a valid/ready stream.
// Define CONV1_SAT_EN to saturate results at 0xFFFF instead of wrapping modulo 2^16.
module conv1_stream_engine
  import conv1_pkg::*;
#(
  parameter int IN_DIM_P  = IN_DIM,
  parameter int OUT_DIM_P = OUT_DIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  conv1_stream_engine_if.master bus
);
  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               rd_vld_q, rd_vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [COORD_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic               out_last_q, out_last_d;
  logic [DATA_W-1:0]  res;
  logic [PROD_W-1:0]  prod;
  logic               tap_en, pix_en, in_bounds, last_tap, last_pix;
  logic [IMG_AW-1:0]  img_addr;
  logic [KER_AW-1:0]  ker_addr;
  logic [COORD_W-1:0] pix_row, pix_col;

  assign tap_en = (state_q == RUN);
  assign pix_en = (state_q == OUT) && bus.out_ready;

  conv1_addr_gen #(.IN_DIM_P(IN_DIM_P), .OUT_DIM_P(OUT_DIM_P)) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .tap_en(tap_en), .pix_en(pix_en),
    .img_addr(img_addr), .ker_addr(ker_addr), .in_bounds(in_bounds),
    .last_tap(last_tap), .last_pix(last_pix), .pix_row(pix_row), .pix_col(pix_col)
  );

  assign bus.img_rd    = tap_en && in_bounds;
  assign bus.img_addr  = img_addr;
  assign bus.ker_addr  = ker_addr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  // Done coincides with acceptance of the final pixel, while the FSM is still in OUT.
  assign done          = pix_en && last_pix;

  assign prod = PROD_W'(bus.img_rdata) * PROD_W'(bus.ker_rdata);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    rd_vld_d    = bus.img_rd;
    acc_d       = rd_vld_q ? acc_q + ACC_W'(prod) : acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (last_tap) state_d = DRAIN;
      end
      DRAIN: begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        out_data_d  = res;
        out_row_d   = pix_row;
        out_col_d   = pix_col;
        out_last_d  = last_pix;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (last_pix) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = RUN;
            acc_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The result is taken from acc_d so the final tap's product lands in this pixel.
  always_comb begin
`ifdef CONV1_SAT_EN
    res = (|acc_d[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : acc_d[DATA_W-1:0];
`else
    res = acc_d[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rd_vld_q    <= rd_vld_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_conv1_stream_engine.sv
// Bench for conv1_stream_engine on a reduced 13x13 image / 3x3 output grid so edge taps fall out of bounds.
module tb_conv1_stream_engine;
  import conv1_pkg::*;

  localparam int TIN     = 13;
  localparam int TOUT    = 3;
  localparam int NPIX    = TOUT * TOUT;
  localparam int PIX_CYC = K * K * CH + 2;
  localparam int IMG_N   = TIN * TIN * CH;
  localparam int KER_N   = K * K * CH;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               last;
  } exp_t;
  typedef struct packed {
    logic [IMG_AW-1:0] ia;
    logic [KER_AW-1:0] ka;
  } ad_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  conv1_stream_engine_if bus();

  conv1_stream_engine #(.IN_DIM_P(TIN), .OUT_DIM_P(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] img_mem [IMG_N];
  logic [DATA_W-1:0] ker_mem [KER_N];
  exp_t exp_q[$];
  ad_t  ad_q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk_addr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One-cycle-latency SRAM/ROM; garbage when no read is issued.
  logic              rd_s;
  logic [IMG_AW-1:0] ia_s;
  logic [KER_AW-1:0] ka_s;
  always @(negedge clk) begin
    rd_s = bus.img_rd;
    ia_s = bus.img_addr;
    ka_s = bus.ker_addr;
  end
  always @(posedge clk) begin
    if (rd_s && int'(ia_s) < IMG_N && int'(ka_s) < KER_N) begin
      bus.img_rdata <= img_mem[int'(ia_s)];
      bus.ker_rdata <= ker_mem[int'(ka_s)];
    end else begin
      bus.img_rdata <= 16'hDEAD;
      bus.ker_rdata <= 16'hBEEF;
    end
  end

  always @(negedge clk) begin
    if (chk_addr && bus.img_rd) begin
      ad_t e;
      if (ad_q.size() == 0) begin
        chk("addr_extra", 64'd1, 64'd0);
      end else begin
        e = ad_q.pop_front();
        chk("addr", {bus.img_addr, bus.ker_addr}, {e.ia, e.ka});
      end
    end
    if (chk_addr && bus.out_valid) chk("rd_in_out", bus.img_rd, 1'b0);
  end

  function automatic logic [DATA_W-1:0] golden(input int i, input int j);
    logic [ACC_W-1:0] acc;
    acc = '0;
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K; n++)
        for (int c = 0; c < CH; c++) begin
          int r, q;
          r = i * STRIDE + m;
          q = j * STRIDE + n;
          if (r < TIN && q < TIN)
            acc = acc + ACC_W'(img_mem[(r * TIN + q) * CH + c]) * ACC_W'(ker_mem[(m * K + n) * CH + c]);
        end
`ifdef CONV1_SAT_EN
    return (acc > ACC_W'(16'hFFFF)) ? 16'hFFFF : acc[DATA_W-1:0];
`else
    return acc[DATA_W-1:0];
`endif
  endfunction

  task automatic push_map();
    exp_t e;
    ad_t  a;
    for (int i = 0; i < TOUT; i++)
      for (int j = 0; j < TOUT; j++) begin
        e.data = golden(i, j);
        e.row  = COORD_W'(i);
        e.col  = COORD_W'(j);
        e.last = (i == TOUT - 1) && (j == TOUT - 1);
        exp_q.push_back(e);
        for (int m = 0; m < K; m++)
          for (int n = 0; n < K; n++)
            for (int c = 0; c < CH; c++)
              if (i * STRIDE + m < TIN && j * STRIDE + n < TIN) begin
                a.ia = IMG_AW'(((i * STRIDE + m) * TIN + j * STRIDE + n) * CH + c);
                a.ka = KER_AW'((m * K + n) * CH + c);
                ad_q.push_back(a);
              end
      end
  endtask

  task automatic fill(input int mode, input logic [DATA_W-1:0] iv, input logic [DATA_W-1:0] kv);
    for (int x = 0; x < IMG_N; x++) img_mem[x] = (mode != 0) ? DATA_W'($urandom) : iv;
    for (int x = 0; x < KER_N; x++) ker_mem[x] = (mode != 0) ? DATA_W'($urandom) : kv;
    exp_q.delete();
    ad_q.delete();
    push_map();
  endtask

  task automatic drive_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle numbering: the start-sampling cycle is 0; samples are taken mid-cycle.
  task automatic wait_map(input bit rnd, input bit pokes, input int stop_at);
    int   cyc = 0;
    int   got = 0;
    bit   stalled = 1'b0;
    bit   seen_done = 1'b0;
    exp_t held, e;
    while (cyc < NPIX * PIX_CYC * 4 && !seen_done && got < stop_at) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = pokes && (cyc == 500);
      #1;
      if (cyc == 1) chk("busy_rise", busy, 1'b1);
      if (!rnd && cyc == 1) chk("first_tap_rd", bus.img_rd, 1'b1);
      if (!rnd && cyc == PIX_CYC - 1) chk("drain_no_rd", {bus.img_rd, bus.out_valid}, 2'b00);
      if (stalled) chk("hold", {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_last},
                       {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        got++;
        stalled = 1'b0;
        if (!rnd && got == 1) chk("first_lat", cyc, PIX_CYC);
        if (exp_q.size() == 0) begin
          chk("extra_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_pos", {bus.out_row, bus.out_col}, {e.row, e.col});
          chk("out_last", bus.out_last, e.last);
        end
      end else begin
        stalled = bus.out_valid;
        held = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_count", got, NPIX);
        if (!rnd) chk("done_cyc", cyc, NPIX * PIX_CYC);
        if (pokes) start = 1'b1;
      end
    end
    if (!seen_done && got < stop_at) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int viol;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {busy, done, bus.img_rd, bus.out_valid, bus.out_last}, 5'b0);
    chk("rst_addr", {bus.img_addr, bus.ker_addr}, '0);
    chk("rst_out", {bus.out_data, bus.out_row, bus.out_col}, '0);
    rst_n = 1'b1;

    // All-ones image and kernel: counts in-bounds taps per window.
    fill(0, 16'd1, 16'd1);
    drive_start();
    wait_map(1'b0, 1'b0, NPIX);
    @(negedge clk);
    #1;
    chk("busy_end_a", busy, 1'b0);
    chk("queue_a", exp_q.size(), 0);

    // 200*3 over a full window wraps in the default build.
    fill(0, 16'd200, 16'd3);
    drive_start();
    wait_map(1'b0, 1'b0, NPIX);
    @(negedge clk);

    // Random data, random backpressure, address order and spurious starts.
    fill(1, '0, '0);
    chk_addr = 1'b1;
    drive_start();
    wait_map(1'b1, 1'b1, NPIX);
    @(negedge clk);
    start = 1'b0;
    chk_addr = 1'b0;
    #1;
    chk("busy_after_done_start", busy, 1'b0);
    chk("addr_queue_empty", ad_q.size(), 0);
    chk("queue_c", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_c", {busy, bus.out_valid}, 2'b00);

    // Reset during RUN of pixel (1,2).
    fill(1, '0, '0);
    drive_start();
    wait_map(1'b0, 1'b0, 5);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_ctrl", {busy, done, bus.img_rd, bus.out_valid, bus.out_last}, 5'b0);
    chk("mid_rst_out", {bus.out_data, bus.out_row, bus.out_col, bus.img_addr, bus.ker_addr}, '0);
    rst_n = 1'b1;
    viol = 0;
    repeat (2 * PIX_CYC) begin
      @(negedge clk);
      #1;
      if (bus.out_valid || done || busy) viol++;
    end
    chk("quiet_after_rst", viol, 0);

    // Clean map after the abandoned one.
    fill(1, '0, '0);
    drive_start();
    wait_map(1'b0, 1'b0, NPIX);
    @(negedge clk);
    chk("queue_e", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
